// File: rtl/spd_slew_lim.sv
// spd_slew_lim
//   Sits between the balance/steer math and mtr_drv. It takes signed left and
//   right wheel speed targets and turns them into the saturated, slew-limited
//   lft_spd/rght_spd that mtr_drv converts to PWM. Speeds change only on
//   PWM_sync, so a duty cycle never changes in the middle of a PWM period.
//   The block also owns over-current handling. On OVR_I_shtdwn it zeroes both
//   speeds and holds them at zero for FLT_PERIODS PWM periods. It then comes
//   back through IDLE, and the speeds ramp up from zero again.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pwr_up       rider present / enable; low ramps the wheels down to IDLE
//   PWM_sync     one-clock strobe per PWM period from mtr_drv
//   lft_tgt      signed 12-bit left speed target
//   rght_tgt     signed 12-bit right speed target
//   OVR_I_shtdwn over-current shutdown level from mtr_drv
//   lft_spd      signed 12-bit slew-limited left speed
//   rght_spd     signed 12-bit slew-limited right speed
//   ovr_flt      high while in FAULT
//   flt_cnt      saturating count of over-current events since reset

module spd_slew_lim #(
    parameter int STEP        = 16,
    parameter int MAX_SPD     = 2000,
    parameter int FLT_PERIODS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwr_up,
    input  logic               PWM_sync,
    input  logic signed [11:0] lft_tgt,
    input  logic signed [11:0] rght_tgt,
    input  logic               OVR_I_shtdwn,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               ovr_flt,
    output logic        [7:0]  flt_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, RAMPDN, FAULT} state_t;

    localparam int                    HOLD_W    = $clog2(FLT_PERIODS + 1);
    localparam logic signed [12:0]    STEP_S    = 13'(STEP);
    localparam logic signed [12:0]    MAX_S     = 13'(MAX_SPD);
    localparam logic [HOLD_W-1:0]     HOLD_DONE = HOLD_W'(FLT_PERIODS);

    state_t             state;
    state_t             next_state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic signed [11:0] lft_nxt;
    logic signed [11:0] rght_nxt;
    logic               flt_entry;
    logic               hold_done;

    // Clamp a 12-bit target to +/-MAX_SPD. The work is done in 13 bits so
    // that -MAX_S is always representable.
    function automatic logic signed [12:0] clamp(input logic signed [11:0] t);
        logic signed [12:0] t_x;
        logic signed [12:0] res;
        t_x = {t[11], t};
        if (t_x > MAX_S)
            res = MAX_S;
        else if (t_x < -MAX_S)
            res = -MAX_S;
        else
            res = t_x;
        return res;
    endfunction

    // Take one step of at most STEP toward tgt. If the target is within STEP,
    // land on it exactly so the output never overshoots. The result always
    // fits in 12 bits because the target is already clamped.
    function automatic logic signed [11:0] slew(input logic signed [12:0] tgt,
                                                input logic signed [11:0] cur);
        logic signed [12:0] cur_x;
        logic signed [12:0] diff;
        logic signed [12:0] nxt;
        cur_x = {cur[11], cur};
        diff  = tgt - cur_x;
        if (diff > STEP_S)
            nxt = cur_x + STEP_S;
        else if (diff < -STEP_S)
            nxt = cur_x - STEP_S;
        else
            nxt = tgt;
        return nxt[11:0];
    endfunction

    assign flt_entry = (state != FAULT) && (next_state == FAULT);
    assign hold_done = (hold_cnt == HOLD_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. Over-current beats every other condition, including
    // a PWM_sync in the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pwr_up)
                    next_state = RUN;
            end
            RUN: begin
                if (OVR_I_shtdwn)
                    next_state = FAULT;
                else if (!pwr_up)
                    next_state = RAMPDN;
            end
            RAMPDN: begin
                if (OVR_I_shtdwn)
                    next_state = FAULT;
                else if (pwr_up)
                    next_state = RUN;
                else if ((lft_spd == 12'sd0) && (rght_spd == 12'sd0))
                    next_state = IDLE;
            end
            FAULT: begin
                if (hold_done && !OVR_I_shtdwn)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode. ovr_flt follows the registered state, so it changes
    // only on a clock edge.
    always_comb begin
        ovr_flt = (state == FAULT);
    end

    // Next speeds. Entering FAULT zeroes the speeds right away, without
    // waiting for PWM_sync. Otherwise speeds move only on PWM_sync.
    // RAMPDN slews toward zero and ignores the targets.
    always_comb begin
        lft_nxt  = lft_spd;
        rght_nxt = rght_spd;
        if (flt_entry) begin
            lft_nxt  = 12'sd0;
            rght_nxt = 12'sd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (PWM_sync) begin
                        lft_nxt  = slew(clamp(lft_tgt), lft_spd);
                        rght_nxt = slew(clamp(rght_tgt), rght_spd);
                    end
                end
                RAMPDN: begin
                    if (PWM_sync) begin
                        lft_nxt  = slew(13'sd0, lft_spd);
                        rght_nxt = slew(13'sd0, rght_spd);
                    end
                end
                default: begin
                    lft_nxt  = 12'sd0;
                    rght_nxt = 12'sd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= 12'sd0;
            rght_spd <= 12'sd0;
        end else begin
            lft_spd  <= lft_nxt;
            rght_spd <= rght_nxt;
        end
    end

    // Fault bookkeeping. The hold counter counts PWM periods spent in FAULT
    // and stops at FLT_PERIODS. flt_cnt counts only entries into FAULT, so a
    // re-assertion while already in FAULT does not add to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            flt_cnt  <= 8'd0;
        end else begin
            if (flt_entry) begin
                hold_cnt <= '0;
                if (flt_cnt != 8'hFF)
                    flt_cnt <= flt_cnt + 8'd1;
            end else if ((state == FAULT) && PWM_sync && !hold_done) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spd_slew_lim.sv
// tb_spd_slew_lim
//   Self-checking bench for spd_slew_lim. Directed scenarios compare the
//   outputs against hand-derived constants. A randomized phase compares them
//   every cycle against an integer reference model of the wheel-speed rules,
//   kept inside the bench.

module tb_spd_slew_lim;

    localparam int STEP    = 16;
    localparam int MAX_SPD = 2000;
    localparam int FLT     = 64;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_RAMPDN = 2;
    localparam int M_FAULT  = 3;

    logic               clk          = 1'b0;
    logic               rst_n        = 1'b0;
    logic               pwr_up       = 1'b0;
    logic               PWM_sync     = 1'b0;
    logic               OVR_I_shtdwn = 1'b0;
    logic signed [11:0] lft_tgt      = 12'sd0;
    logic signed [11:0] rght_tgt     = 12'sd0;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               ovr_flt;
    logic        [7:0]  flt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, using plain integers.
    int m_lft  = 0;
    int m_rght = 0;
    int m_cnt  = 0;
    int m_hold = 0;
    int m_mode = M_IDLE;
    bit m_was_zero;

    spd_slew_lim #(.STEP(STEP), .MAX_SPD(MAX_SPD), .FLT_PERIODS(FLT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwr_up       (pwr_up),
        .PWM_sync     (PWM_sync),
        .lft_tgt      (lft_tgt),
        .rght_tgt     (rght_tgt),
        .OVR_I_shtdwn (OVR_I_shtdwn),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .ovr_flt      (ovr_flt),
        .flt_cnt      (flt_cnt)
    );

    always #5 clk = ~clk;

    function automatic int clamp_i(int t);
        if (t > MAX_SPD)  return MAX_SPD;
        if (t < -MAX_SPD) return -MAX_SPD;
        return t;
    endfunction

    function automatic int toward(int cur, int tgt);
        if (tgt - cur > STEP)  return cur + STEP;
        if (tgt - cur < -STEP) return cur - STEP;
        return tgt;
    endfunction

    task automatic m_enter_fault();
        m_lft  = 0;
        m_rght = 0;
        m_hold = 0;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        m_mode = M_FAULT;
    endtask

    // Reference model: applies the wheel-speed rules once per clock, using the
    // inputs as they stand at the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lft = 0; m_rght = 0; m_cnt = 0; m_hold = 0; m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_lft = 0; m_rght = 0;
                    if (pwr_up) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (OVR_I_shtdwn) m_enter_fault();
                    else begin
                        if (PWM_sync) begin
                            m_lft  = toward(m_lft,  clamp_i(int'(lft_tgt)));
                            m_rght = toward(m_rght, clamp_i(int'(rght_tgt)));
                        end
                        if (!pwr_up) m_mode = M_RAMPDN;
                    end
                end
                M_RAMPDN: begin
                    if (OVR_I_shtdwn) m_enter_fault();
                    else begin
                        m_was_zero = (m_lft == 0) && (m_rght == 0);
                        if (PWM_sync) begin
                            m_lft  = toward(m_lft, 0);
                            m_rght = toward(m_rght, 0);
                        end
                        if (pwr_up) m_mode = M_RUN;
                        else if (m_was_zero) m_mode = M_IDLE;
                    end
                end
                default: begin
                    m_lft = 0; m_rght = 0;
                    if (m_hold == FLT && !OVR_I_shtdwn) m_mode = M_IDLE;
                    else if (PWM_sync && m_hold < FLT) m_hold = m_hold + 1;
                end
            endcase
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sync();
        PWM_sync = 1'b1;
        @(posedge clk);
        #1;
        PWM_sync = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwr_up = 1'b0; lft_tgt = 12'sd0; rght_tgt = 12'sd0;
        #12;
        n_checks++; if (lft_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL reset lft_spd got=%0d exp=0", lft_spd); end
        n_checks++; if (rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL reset rght_spd got=%0d exp=0", rght_spd); end
        n_checks++; if (ovr_flt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset ovr_flt got=%b exp=0", ovr_flt); end
        n_checks++; if (flt_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset flt_cnt got=%0d exp=0", flt_cnt); end
        rst_n = 1'b1;
        idle(2);
        n_checks++; if (lft_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL reset_release lft_spd got=%0d exp=0", lft_spd); end
    endtask

    task automatic test_ramp_up();
        int exp_l[8] = '{16, 32, 48, 64, 80, 96, 100, 100};
        lft_tgt = 12'sd100; rght_tgt = 12'sd0; pwr_up = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) begin
            pulse_sync();
            n_checks++; if (lft_spd !== 12'(exp_l[i])) begin n_fail++; $display("[TB] FAIL ramp_up[%0d] lft_spd got=%0d exp=%0d", i, lft_spd, exp_l[i]); end
            n_checks++; if (rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL ramp_up[%0d] rght_spd got=%0d exp=0", i, rght_spd); end
            idle(3);
            n_checks++; if (lft_spd !== 12'(exp_l[i])) begin n_fail++; $display("[TB] FAIL ramp_up_hold[%0d] lft_spd got=%0d exp=%0d", i, lft_spd, exp_l[i]); end
        end
    endtask

    task automatic test_reverse();
        int exp_l[10] = '{84, 68, 52, 36, 20, 4, -12, -28, -40, -40};
        lft_tgt = -12'sd40;
        for (int i = 0; i < 10; i++) begin
            pulse_sync();
            idle(1);
            n_checks++; if (lft_spd !== 12'(exp_l[i])) begin n_fail++; $display("[TB] FAIL reverse[%0d] lft_spd got=%0d exp=%0d", i, lft_spd, exp_l[i]); end
            n_checks++; if (rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL reverse[%0d] rght_spd got=%0d exp=0", i, rght_spd); end
        end
    endtask

    task automatic test_saturation();
        rght_tgt = 12'sd2047;
        repeat (124) begin pulse_sync(); idle(1); end
        n_checks++; if (rght_spd !== 12'sd1984) begin n_fail++; $display("[TB] FAIL sat_pos_approach rght_spd got=%0d exp=1984", rght_spd); end
        pulse_sync(); idle(1);
        n_checks++; if (rght_spd !== 12'sd2000) begin n_fail++; $display("[TB] FAIL sat_pos rght_spd got=%0d exp=2000", rght_spd); end
        repeat (15) begin pulse_sync(); idle(1); end
        n_checks++; if (rght_spd !== 12'sd2000) begin n_fail++; $display("[TB] FAIL sat_pos_stay rght_spd got=%0d exp=2000", rght_spd); end
        rght_tgt = -12'sd2048;
        repeat (250) begin pulse_sync(); idle(1); end
        n_checks++; if (rght_spd !== -12'sd2000) begin n_fail++; $display("[TB] FAIL sat_neg rght_spd got=%0d exp=-2000", rght_spd); end
        repeat (20) begin pulse_sync(); idle(1); end
        n_checks++; if (rght_spd !== -12'sd2000) begin n_fail++; $display("[TB] FAIL sat_neg_stay rght_spd got=%0d exp=-2000", rght_spd); end
        n_checks++; if (lft_spd !== -12'sd40) begin n_fail++; $display("[TB] FAIL sat_lft_indep lft_spd got=%0d exp=-40", lft_spd); end
    endtask

    task automatic test_rampdown();
        int exp_dn[6]  = '{80, 64, 48, 32, 16, 0};
        int exp_mid[9] = '{16, 32, 48, 32, 16, 32, 48, 64, 80};
        lft_tgt = 12'sd96; rght_tgt = 12'sd0;
        repeat (140) begin pulse_sync(); idle(1); end
        n_checks++; if (lft_spd !== 12'sd96) begin n_fail++; $display("[TB] FAIL rampdn_start lft_spd got=%0d exp=96", lft_spd); end
        n_checks++; if (rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL rampdn_start rght_spd got=%0d exp=0", rght_spd); end
        pwr_up = 1'b0; idle(1);
        for (int i = 0; i < 6; i++) begin
            pulse_sync(); idle(1);
            n_checks++; if (lft_spd !== 12'(exp_dn[i])) begin n_fail++; $display("[TB] FAIL rampdn[%0d] lft_spd got=%0d exp=%0d", i, lft_spd, exp_dn[i]); end
        end
        idle(2);
        repeat (3) begin pulse_sync(); idle(1); end
        n_checks++; if (lft_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL rampdn_idle lft_spd got=%0d exp=0", lft_spd); end
        // Power back up, ramp partway, drop pwr_up, then raise it again mid ramp-down.
        pwr_up = 1'b1; idle(1);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin pwr_up = 1'b0; idle(1); end
            if (i == 5) begin pwr_up = 1'b1; idle(1); end
            pulse_sync(); idle(1);
            n_checks++; if (lft_spd !== 12'(exp_mid[i])) begin n_fail++; $display("[TB] FAIL resume[%0d] lft_spd got=%0d exp=%0d", i, lft_spd, exp_mid[i]); end
        end
    endtask

    task automatic test_fault_pulse();
        lft_tgt = 12'sd500; rght_tgt = -12'sd300;
        repeat (30) begin pulse_sync(); idle(1); end
        n_checks++; if (lft_spd !== 12'sd500 || rght_spd !== -12'sd300) begin n_fail++; $display("[TB] FAIL fault_pre speeds got=%0d/%0d exp=500/-300", lft_spd, rght_spd); end
        PWM_sync = 1'b1; OVR_I_shtdwn = 1'b1;
        @(posedge clk); #1;
        PWM_sync = 1'b0; OVR_I_shtdwn = 1'b0;
        n_checks++; if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL fault_zero speeds got=%0d/%0d exp=0/0", lft_spd, rght_spd); end
        n_checks++; if (ovr_flt !== 1'b1) begin n_fail++; $display("[TB] FAIL fault_entry ovr_flt got=%b exp=1", ovr_flt); end
        n_checks++; if (flt_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL fault_entry flt_cnt got=%0d exp=1", flt_cnt); end
        repeat (63) begin pulse_sync(); idle(1); end
        n_checks++; if (ovr_flt !== 1'b1) begin n_fail++; $display("[TB] FAIL fault_63 ovr_flt got=%b exp=1", ovr_flt); end
        n_checks++; if (lft_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL fault_63 lft_spd got=%0d exp=0", lft_spd); end
        pulse_sync(); idle(1);
        n_checks++; if (ovr_flt !== 1'b0) begin n_fail++; $display("[TB] FAIL fault_64 ovr_flt got=%b exp=0", ovr_flt); end
        idle(1);
        pulse_sync(); idle(1);
        n_checks++; if (lft_spd !== 12'sd16 || rght_spd !== -12'sd16) begin n_fail++; $display("[TB] FAIL fault_restart1 speeds got=%0d/%0d exp=16/-16", lft_spd, rght_spd); end
        pulse_sync(); idle(1);
        n_checks++; if (lft_spd !== 12'sd32 || rght_spd !== -12'sd32) begin n_fail++; $display("[TB] FAIL fault_restart2 speeds got=%0d/%0d exp=32/-32", lft_spd, rght_spd); end
        n_checks++; if (flt_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL fault_restart flt_cnt got=%0d exp=1", flt_cnt); end
    endtask

    task automatic test_fault_hold();
        OVR_I_shtdwn = 1'b1;
        idle(1);
        n_checks++; if (flt_cnt !== 8'd2) begin n_fail++; $display("[TB] FAIL hold_entry flt_cnt got=%0d exp=2", flt_cnt); end
        repeat (10) begin pulse_sync(); idle(1); end
        OVR_I_shtdwn = 1'b0; idle(1);
        OVR_I_shtdwn = 1'b1; idle(1);
        n_checks++; if (flt_cnt !== 8'd2) begin n_fail++; $display("[TB] FAIL hold_reassert flt_cnt got=%0d exp=2", flt_cnt); end
        n_checks++; if (ovr_flt !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_reassert ovr_flt got=%b exp=1", ovr_flt); end
        repeat (100) begin pulse_sync(); idle(1); end
        n_checks++; if (ovr_flt !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_100 ovr_flt got=%b exp=1", ovr_flt); end
        n_checks++; if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL hold_100 speeds got=%0d/%0d exp=0/0", lft_spd, rght_spd); end
        n_checks++; if (flt_cnt !== 8'd2) begin n_fail++; $display("[TB] FAIL hold_100 flt_cnt got=%0d exp=2", flt_cnt); end
        OVR_I_shtdwn = 1'b0;
        idle(1);
        n_checks++; if (ovr_flt !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_release ovr_flt got=%b exp=0", ovr_flt); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            PWM_sync = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) lft_tgt = 12'($urandom);
            if ($urandom_range(0, 39) == 0) rght_tgt = 12'($urandom);
            if ($urandom_range(0, 149) == 0) pwr_up = ~pwr_up;
            if (OVR_I_shtdwn) begin
                if ($urandom_range(0, 3) == 0) OVR_I_shtdwn = 1'b0;
            end else if (m_mode != M_IDLE && $urandom_range(0, 299) == 0) begin
                OVR_I_shtdwn = 1'b1;
            end
            @(posedge clk); #1;
            n_checks++; if (lft_spd !== 12'(m_lft)) begin n_fail++; $display("[TB] FAIL random[%0d] lft_spd got=%0d exp=%0d", cyc, lft_spd, m_lft); end
            n_checks++; if (rght_spd !== 12'(m_rght)) begin n_fail++; $display("[TB] FAIL random[%0d] rght_spd got=%0d exp=%0d", cyc, rght_spd, m_rght); end
            n_checks++; if (ovr_flt !== (m_mode == M_FAULT)) begin n_fail++; $display("[TB] FAIL random[%0d] ovr_flt got=%b exp=%b", cyc, ovr_flt, (m_mode == M_FAULT)); end
            n_checks++; if (flt_cnt !== 8'(m_cnt)) begin n_fail++; $display("[TB] FAIL random[%0d] flt_cnt got=%0d exp=%0d", cyc, flt_cnt, m_cnt); end
        end
        PWM_sync = 1'b0; OVR_I_shtdwn = 1'b0;
    endtask

    task automatic test_reset_mid();
        pwr_up = 1'b1; lft_tgt = 12'sd500; rght_tgt = 12'sd500;
        idle(3);
        repeat (5) begin pulse_sync(); idle(1); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin n_fail++; $display("[TB] FAIL reset_mid_ramp speeds got=%0d/%0d exp=0/0", lft_spd, rght_spd); end
        @(negedge clk); rst_n = 1'b1;
        idle(2);
        OVR_I_shtdwn = 1'b1; idle(1);
        n_checks++; if (ovr_flt !== 1'b1 || flt_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL reset_mid_fault_entry ovr_flt/flt_cnt got=%b/%0d exp=1/1", ovr_flt, flt_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ovr_flt !== 1'b0 || flt_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_mid_fault ovr_flt/flt_cnt got=%b/%0d exp=0/0", ovr_flt, flt_cnt); end
        OVR_I_shtdwn = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_saturation();
        test_rampdown();
        test_fault_pulse();
        test_fault_hold();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
